// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM and its decoder.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ACC_NONE = 3'b000;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_MEM_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVF_TRAP    = 2'd2;

    typedef struct packed {
        logic       mem_to_reg;
        logic       pc_src;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [2:0] alu_control;
        logic [2:0] acc_control;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/host bundle; master is the controller side.
interface multicycle_ctrl_if #(
    parameter int unsigned RET_W = 16
);
    logic             start;
    logic [8:0]       inst;
    logic             BranchFlag;
    logic             overflow;
    logic             mem_ready;
    logic             MemToReg;
    logic             PcSrc;
    logic             ALUSrc;
    logic             RegWrite;
    logic             Jump;
    logic [2:0]       ALUControl;
    logic [2:0]       AccControl;
    logic             PcWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             busy;
    logic             halted;
    logic [1:0]       err_code;
    logic [RET_W-1:0] retired;

    modport master (
        input  start, inst, BranchFlag, overflow, mem_ready,
        output MemToReg, PcSrc, ALUSrc, RegWrite, Jump, ALUControl, AccControl,
               PcWrite, MemRead, MemWrite, busy, halted, err_code, retired
    );

    modport slave (
        output start, inst, BranchFlag, overflow, mem_ready,
        input  MemToReg, PcSrc, ALUSrc, RegWrite, Jump, ALUControl, AccControl,
               PcWrite, MemRead, MemWrite, busy, halted, err_code, retired
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational control decode from FSM state and the latched opcode.
module ctrl_decode
    import multicycle_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       branch_flag,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl             = '0;
        ctrl.alu_control = ALU_ADD;
        ctrl.acc_control = ACC_NONE;
        unique case (state)
            S_EXEC, S_WB: begin
                // WB keeps the EXEC operand/ALU selection so the result stays stable at writeback.
                unique case (opcode)
                    OP_SUB:               ctrl.alu_control = ALU_SUB;
                    OP_ADDI, OP_LW, OP_SW: ctrl.alu_src    = 1'b1;
                    default: ;
                endcase
                if (state == S_EXEC) begin
                    unique case (opcode)
                        OP_JMP: begin
                            ctrl.jump     = 1'b1;
                            ctrl.pc_write = 1'b1;
                        end
                        OP_BEQ: begin
                            ctrl.alu_control = ALU_SUB;
                            ctrl.pc_src      = branch_flag;
                            ctrl.pc_write    = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.mem_to_reg = (opcode == OP_LW);
                end
            end
            S_MEM: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
                // SW has no WB cycle, so the pc advances in the MEM cycle that completes.
                ctrl.pc_write  = (opcode == OP_SW) && mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory timeout, optional overflow trap and a saturating retired-instruction counter.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          TRAP_ON_OVF = 1'b0,
    parameter int unsigned RET_W       = 16
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    state_t           state;
    logic [8:0]       ir;
    logic [3:0]       wait_cnt;
    logic [1:0]       err;
    logic [RET_W-1:0] retired;
    logic [2:0]       opcode;
    logic             retire;
    ctrl_t            ctrl;

    assign opcode = ir[8:6];

    // Operand fields are consumed by the datapath straight from instruction memory.
    logic ir_fields_unused;
    assign ir_fields_unused = ^ir[5:0];

    always_comb begin
        retire = 1'b0;
        unique case (state)
            S_EXEC:  retire = (opcode == OP_JMP) || (opcode == OP_BEQ);
            S_MEM:   retire = (opcode == OP_SW) && bus.mem_ready;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            wait_cnt <= '0;
            err      <= ERR_NONE;
            retired  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= bus.inst;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= (opcode == OP_HALT) ? S_HALTED : S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (TRAP_ON_OVF && is_arith(opcode) && bus.overflow) begin
                        state <= S_HALTED;
                        err   <= ERR_OVF_TRAP;
                    end else if (is_arith(opcode)) begin
                        state <= S_WB;
                    end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        state <= (opcode == OP_LW) ? S_WB : S_FETCH;
                    end else if (wait_cnt == 4'(MEM_TIMEOUT - 1)) begin
                        state <= S_HALTED;
                        err   <= ERR_MEM_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALTED: begin
                    if (bus.start) begin
                        err   <= ERR_NONE;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (retire && (retired != '1)) retired <= retired + 1'b1;
        end
    end

    ctrl_decode u_decode (
        .state       (state),
        .opcode      (opcode),
        .branch_flag (bus.BranchFlag),
        .mem_ready   (bus.mem_ready),
        .ctrl        (ctrl)
    );

    assign bus.MemToReg   = ctrl.mem_to_reg;
    assign bus.PcSrc      = ctrl.pc_src;
    assign bus.ALUSrc     = ctrl.alu_src;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.Jump       = ctrl.jump;
    assign bus.ALUControl = ctrl.alu_control;
    assign bus.AccControl = ctrl.acc_control;
    assign bus.PcWrite    = ctrl.pc_write;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.busy       = (state != S_IDLE) && (state != S_HALTED);
    assign bus.halted     = (state == S_HALTED);
    assign bus.err_code   = err;
    assign bus.retired    = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control trace and compares every cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_to_reg;
        logic       pc_src;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [2:0] alu;
        logic [2:0] acc;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       busy;
        logic       halted;
        logic [1:0] err;
    } ctl_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic [8:0] inst = '0;
    logic       branch_flag = 1'b0;
    logic       ovf = 1'b0;
    logic       ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc_no = 0;
    int phase = 0;

    int       exp_ret = 0;
    int       ret_max = 65535;
    int       mode = M_IDLE;
    logic [1:0] exp_err = 2'd0;
    bit       trap_on = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.RET_W(16)) bus_a ();
    multicycle_ctrl_if #(.RET_W(4))  bus_b ();

    assign bus_a.start = start;       assign bus_b.start = start;
    assign bus_a.inst = inst;         assign bus_b.inst = inst;
    assign bus_a.BranchFlag = branch_flag; assign bus_b.BranchFlag = branch_flag;
    assign bus_a.overflow = ovf;      assign bus_b.overflow = ovf;
    assign bus_a.mem_ready = ready;   assign bus_b.mem_ready = ready;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .TRAP_ON_OVF(1'b0), .RET_W(16)) dut (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(15), .TRAP_ON_OVF(1'b1), .RET_W(4)) dut_trap (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [8:0] ri();
        return 9'($urandom);
    endfunction

    function automatic ctl_t quiet();
        ctl_t c;
        c        = '0;
        c.alu    = 3'b010;
        c.halted = (mode == M_HALT);
        c.err    = exp_err;
        return c;
    endfunction

    function automatic ctl_t active();
        ctl_t c;
        c      = '0;
        c.alu  = 3'b010;
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic int rand_waits();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 5;
        if (r < 16) return 14;
        if (r < 18) return 13;
        return 15 + (r - 18);
    endfunction

    task automatic bump_retired();
        exp_ret = (exp_ret >= ret_max) ? ret_max : exp_ret + 1;
    endtask

    task automatic cyc(input logic st, input logic [8:0] in_v, input logic bf, input logic ov,
                       input logic rdy, input logic r, input ctl_t e);
        ctl_t        obs;
        logic [15:0] ro;
        @(posedge clk);
        #1;
        start       = st;
        inst        = in_v;
        branch_flag = bf;
        ovf         = ov;
        ready       = rdy;
        rst_a       = (phase != 0) ? 1'b1 : r;
        rst_b       = (phase != 0) ? r : 1'b1;
        #3;
        if (phase == 0) begin
            obs = {bus_a.MemToReg, bus_a.PcSrc, bus_a.ALUSrc, bus_a.RegWrite, bus_a.Jump,
                   bus_a.ALUControl, bus_a.AccControl, bus_a.PcWrite, bus_a.MemRead,
                   bus_a.MemWrite, bus_a.busy, bus_a.halted, bus_a.err_code};
            ro  = bus_a.retired;
        end else begin
            obs = {bus_b.MemToReg, bus_b.PcSrc, bus_b.ALUSrc, bus_b.RegWrite, bus_b.Jump,
                   bus_b.ALUControl, bus_b.AccControl, bus_b.PcWrite, bus_b.MemRead,
                   bus_b.MemWrite, bus_b.busy, bus_b.halted, bus_b.err_code};
            ro  = {12'd0, bus_b.retired};
        end
        check($sformatf("ctl p%0d c%0d", phase, cyc_no), 32'(obs), 32'(e));
        check($sformatf("retired p%0d c%0d", phase, cyc_no), 32'(ro), 32'(exp_ret));
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, ri(), rb(), rb(), rb(), 1'b0, quiet());
    endtask

    task automatic kick();
        cyc(1'b1, ri(), rb(), rb(), rb(), 1'b0, quiet());
        exp_err = 2'd0;
        mode    = M_RUN;
    endtask

    // One instruction from FETCH to its last cycle; start pulses while busy must be ignored.
    task automatic run_instr(input logic [2:0] op, input int waits, input logic bf,
                             input logic ov, input int rst_at);
        ctl_t e;
        logic rdy;
        logic arith;
        arith = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
        cyc(rb(), {op, 6'($urandom)}, rb(), rb(), rb(), 1'b0, active());
        cyc(rb(), ri(), rb(), rb(), rb(), 1'b0, active());
        if (op == 3'd7) begin
            mode = M_HALT;
            return;
        end
        e = active();
        if (op == 3'd1) e.alu = 3'b110;
        if (op == 3'd4 || op == 3'd5 || op == 3'd6) e.alu_src = 1'b1;
        if (op == 3'd2) begin
            e.jump     = 1'b1;
            e.pc_write = 1'b1;
        end
        if (op == 3'd3) begin
            e.alu      = 3'b110;
            e.pc_src   = bf;
            e.pc_write = 1'b1;
        end
        cyc(rb(), ri(), bf, ov, rb(), 1'b0, e);
        if (op == 3'd2 || op == 3'd3) begin
            bump_retired();
            return;
        end
        if (arith && trap_on && ov) begin
            mode    = M_HALT;
            exp_err = 2'd2;
            return;
        end
        if (op == 3'd4 || op == 3'd5) begin
            for (int i = 0; i < 32; i++) begin
                rdy         = (i == waits);
                e           = active();
                e.alu_src   = 1'b1;
                e.mem_read  = (op == 3'd4);
                e.mem_write = (op == 3'd5);
                e.pc_write  = (op == 3'd5) && rdy;
                cyc(rb(), ri(), rb(), rb(), rdy, (i == rst_at), e);
                if (i == rst_at) begin
                    mode    = M_IDLE;
                    exp_ret = 0;
                    exp_err = 2'd0;
                    return;
                end
                if (rdy) break;
                if (i == 14) begin
                    mode    = M_HALT;
                    exp_err = 2'd1;
                    return;
                end
            end
            if (op == 3'd5) begin
                bump_retired();
                return;
            end
            e         = active();
            e.alu_src = 1'b1;
        end
        e.reg_write  = 1'b1;
        e.pc_write   = 1'b1;
        e.mem_to_reg = (op == 3'd4);
        cyc(rb(), ri(), rb(), rb(), rb(), 1'b0, e);
        bump_retired();
    endtask

    task automatic random_run(input int n);
        logic [2:0] op;
        for (int k = 0; k < n; k++) begin
            if (mode != M_RUN) begin
                idle($urandom_range(0, 2));
                kick();
            end
            op = 3'($urandom);
            if (op == 3'd7 && rb()) op = 3'd0;
            run_instr(op, rand_waits(), rb(), rb(), -1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Default controller: reset state, directed instructions, then random traffic.
        cyc(1'b0, ri(), rb(), rb(), rb(), 1'b1, quiet());
        idle(1);
        kick();
        run_instr(3'd0, 0, rb(), 1'b1, -1);
        run_instr(3'd4, 3, rb(), rb(), -1);
        run_instr(3'd2, 0, rb(), rb(), -1);
        run_instr(3'd3, 0, 1'b1, rb(), -1);
        run_instr(3'd3, 0, 1'b0, rb(), -1);
        run_instr(3'd5, 20, rb(), rb(), -1);
        idle(2);
        kick();
        run_instr(3'd0, 0, rb(), rb(), -1);
        run_instr(3'd4, 14, rb(), rb(), -1);
        run_instr(3'd5, 5, rb(), rb(), 2);
        idle(1);
        kick();
        run_instr(3'd7, 0, rb(), rb(), -1);
        idle(2);
        kick();
        random_run(150);

        // Trapping controller with a 4-bit retired counter.
        phase   = 1;
        trap_on = 1'b1;
        ret_max = 15;
        exp_ret = 0;
        exp_err = 2'd0;
        mode    = M_IDLE;
        cyc(1'b0, ri(), rb(), rb(), rb(), 1'b1, quiet());
        kick();
        run_instr(3'd0, 0, rb(), 1'b1, -1);
        idle(2);
        kick();
        run_instr(3'd1, 0, rb(), 1'b0, -1);
        repeat (20) run_instr(3'd5, 0, rb(), rb(), -1);
        random_run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
